adder_rr_arbiter: RTL and testbench
===================================

// Module: adder_rr_arbiter
// PURPOSE
//  Shares one adder_32bits carry-select datapath between NUM_REQ requesters.
//  Round-robin arbitration selects one valid request per cycle and routes its operands through the shared adder.
//  The sum, carry-out and requester id are registered into a single response slot with valid/ready backpressure.
//  Sits between the multiplier/accumulate front ends and the shared 32-bit add resource.
// PARAMETERS
//  NUM_REQ  4  number of requesters; legal range 2..8
//  ID_W     localparam = $clog2(NUM_REQ); width of rsp_id
// PORTS
//  clk        in   1             single clock; all state on rising edge
//  rst        in   1             synchronous, active-high reset
//  req_valid  in   NUM_REQ       bit i: requester i presents operands
//  req_ready  out  NUM_REQ       bit i: request i accepted this cycle (one-hot or zero)
//  req_a      in   NUM_REQ*32    operand a, requester i at [32*i+31:32*i]
//  req_b      in   NUM_REQ*32    operand b, same packing
//  req_ci     in   NUM_REQ       carry-in per requester
//  rsp_valid  out  1             response slot holds a result
//  rsp_ready  in   1             consumer takes response this cycle
//  rsp_id     out  ID_W          index of requester that owns the result
//  rsp_s      out  32            sum
//  rsp_co     out  1             carry-out
// BEHAVIOUR
//  Reset: rsp_valid=0, rsp_s=0, rsp_co=0, rsp_id=0, rr pointer ptr=0, state=EMPTY. req_ready=0 while rst=1.
//  Slot FSM: EMPTY (rsp_valid=0) / FULL (rsp_valid=1).
//   - can_accept = EMPTY | (FULL & rsp_ready).
//   - EMPTY -> FULL on accept; FULL -> EMPTY on rsp_ready with no accept.
//   - FULL stays FULL on accept with drain in the same cycle; the slot reloads with new data.
//  Grant: g = first i with req_valid[i], searching ptr, ptr+1, ... modulo NUM_REQ.
//   - req_ready[g]=1 only if can_accept and any req_valid; all other bits are 0.
//   - req_ready is combinational from req_valid, ptr and slot state.
//  Accept (req_valid[g] & req_ready[g]):
//   - The adder sees req_a/req_b/req_ci of g in this same cycle.
//   - rsp_s/rsp_co/rsp_id<=g load at the next edge.
//   - Latency: 1 cycle, request handshake to rsp_valid.
//   - Throughput: 1 result per cycle while rsp_ready=1.
//  ptr <= (g+1) mod NUM_REQ on accept only; ptr holds when there is no accept.
//  With no request valid, the adder inputs still carry requester ptr's operands, but nothing is captured.
//  Backpressure: FULL & !rsp_ready holds rsp_* stable and drives all req_ready to 0.
//  Requester rule (bench-checked, not relied on): once valid, hold operands stable until ready.
//   - A requester that drops valid forfeits its turn and gets no penalty.
//  Arithmetic: {rsp_co,rsp_s} = a + b + ci, modulo 2^33; no saturation. Overflow is reported via co only.
//  Reset mid-operation: a pending response is discarded (rsp_valid=0 next cycle); ptr returns to 0.
// STRUCTURE
//  adder_arb_pkg:
//   - DATA_W=32
//   - slot state encodings ST_EMPTY=1'b0, ST_FULL=1'b1
//   - NUM_REQ_MAX=8
//  Sub-module rr_pick:
//   - combinational rotate-priority picker
//   - inputs: req vector, ptr
//   - outputs: one-hot grant, binary index, any flag
//  One adder_32bits instance, fed by an operand mux indexed by the rr_pick index.
//  Top level holds only the slot FSM, ptr and response registers.
// TESTING
//  1. Reset, then single request: req0 a=32'h0000_0001 b=32'h0000_0002 ci=0, rsp_ready=1.
//     -> next cycle rsp_valid=1, rsp_s=3, rsp_co=0, rsp_id=0.
//  2. Carry chain: a=32'hFFFF_FFFF b=0 ci=1.
//     -> rsp_s=0, rsp_co=1.
//  3. Carry chain: a=32'h8000_0000 b=32'h8000_0000 ci=0.
//     -> rsp_s=0, rsp_co=1.
//  4. Fairness: all 4 requesters held valid, rsp_ready=1.
//     -> rsp_id sequence 0,1,2,3,0,1 on consecutive cycles; exactly one req_ready bit per cycle.
//  5. Backpressure: rsp_ready=0 for 3 cycles with req1,req2 valid.
//     -> rsp_* frozen, req_ready=0.
//     -> on rsp_ready=1, drain and accept in the same cycle; the next id follows the round-robin order.
//  6. Reset mid-stream: assert rst while FULL with req2 valid.
//     -> next cycle rsp_valid=0, req_ready=0.
//     -> after release, first grant is the lowest valid index >= 0.
//  7. Random: constrained-random valid/ready traffic.
//     -> scoreboard matches a+b+ci per id.
//     -> no request is lost or duplicated.
//     -> every valid requester is granted within NUM_REQ accepts.

Source files
------------

// File: rtl/adder_arb_pkg.sv
// Shared constants and slot-state encoding for the round-robin adder arbiter.
package adder_arb_pkg;

  localparam int DATA_W      = 32;
  localparam int NUM_REQ_MAX = 8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/adder_32bits.sv
// 32-bit carry-select adder: the low half ripples, the high half is precomputed
// for both possible carries and selected by the low-half carry-out.
module adder_32bits
  import adder_arb_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              ci,
  output logic [DATA_W-1:0] s,
  output logic              co
);

  localparam int HALF = DATA_W / 2;

  logic [HALF:0] lo_sum;
  logic [HALF:0] hi_sum0;
  logic [HALF:0] hi_sum1;

  assign lo_sum  = {1'b0, a[HALF-1:0]} + {1'b0, b[HALF-1:0]} + {{HALF{1'b0}}, ci};
  assign hi_sum0 = {1'b0, a[DATA_W-1:HALF]} + {1'b0, b[DATA_W-1:HALF]};
  assign hi_sum1 = {1'b0, a[DATA_W-1:HALF]} + {1'b0, b[DATA_W-1:HALF]} + {{HALF{1'b0}}, 1'b1};

  assign s  = lo_sum[HALF] ? {hi_sum1[HALF-1:0], lo_sum[HALF-1:0]}
                           : {hi_sum0[HALF-1:0], lo_sum[HALF-1:0]};
  assign co = lo_sum[HALF] ? hi_sum1[HALF] : hi_sum0[HALF];

endmodule

// File: rtl/adder_rr_arbiter_rr_pick.sv
// Rotating-priority picker: finds the first set request starting at ptr and
// wrapping modulo N. With no request set, idx stays at ptr.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  // Walk from the lowest priority upward so the highest-priority hit wins last.
  always_comb begin
    idx   = ptr;
    grant = '0;
    cand  = '0;
    any   = |req;
    for (int k = N - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr) + k) % N);
      if (req[cand]) idx = cand;
    end
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/adder_rr_arbiter.sv
// Shares one 32-bit adder among NUM_REQ requesters with round-robin grants and
// a single registered response slot under valid/ready backpressure.
module adder_rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ-1:0]        req_ci,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_s,
  output logic                      rsp_co
);

  slot_state_t        state, state_nxt;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    pick_idx;
  logic [NUM_REQ-1:0] pick_grant;
  logic               pick_any;
  logic               can_accept;
  logic               accept;

  logic [DATA_W-1:0]  a_arr [NUM_REQ];
  logic [DATA_W-1:0]  b_arr [NUM_REQ];
  logic [DATA_W-1:0]  sel_a, sel_b;
  logic               sel_ci;
  logic [DATA_W-1:0]  sum;
  logic               carry;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[DATA_W*i +: DATA_W];
    assign b_arr[i] = req_b[DATA_W*i +: DATA_W];
  end

  rr_pick #(.N(NUM_REQ), .IW(ID_W)) u_pick (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // The adder always sees the picked requester's operands, even when idle.
  assign sel_a  = a_arr[pick_idx];
  assign sel_b  = b_arr[pick_idx];
  assign sel_ci = req_ci[pick_idx];

  adder_32bits u_add (
    .a  (sel_a),
    .b  (sel_b),
    .ci (sel_ci),
    .s  (sum),
    .co (carry)
  );

  assign rsp_valid = (state == ST_FULL);

  always_comb begin
    can_accept = (state == ST_EMPTY) || rsp_ready;
    req_ready  = '0;
    if (!rst && can_accept && pick_any) req_ready = pick_grant;
    accept     = |req_ready;
    state_nxt  = state;
    case (state)
      ST_EMPTY: if (accept) state_nxt = ST_FULL;
      ST_FULL:  if (rsp_ready && !accept) state_nxt = ST_EMPTY;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_EMPTY;
      ptr    <= '0;
      rsp_s  <= '0;
      rsp_co <= 1'b0;
      rsp_id <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rsp_s  <= sum;
        rsp_co <= carry;
        rsp_id <= pick_idx;
        ptr    <= (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + ID_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Scoreboard bench for adder_rr_arbiter: the driver predicts grants and sums
// from a rotating-priority model, the monitor checks every presented response.
module tb_adder_rr_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_a = '0;
  logic [N*32-1:0] req_b = '0;
  logic [N-1:0]    req_ci = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [IDW-1:0]  rsp_id;
  logic [31:0]     rsp_s;
  logic            rsp_co;

  adder_rr_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ci    (req_ci),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_s     (rsp_s),
    .rsp_co    (rsp_co)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          id;
    logic [32:0] sum;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] op_a [N];
  logic [31:0] op_b [N];
  logic        op_ci[N];
  int          m_ptr;
  bit          m_full;
  int          waits[N];
  int          issued[N];
  int          recv[N];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive at negedge, check grants and update the model 2ns later.
  task automatic applyStimulus(input logic r, input logic [N-1:0] v, input logic rr, output int dut_g);
    int          exp_g;
    bit          can;
    logic [N-1:0] exp_rdy;
    logic [32:0] s;
    @(negedge clk);
    rst       = r;
    req_valid = v;
    rsp_ready = rr;
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = op_a[i];
      req_b[32*i +: 32] = op_b[i];
      req_ci[i]         = op_ci[i];
    end
    #2;
    dut_g = -1;
    for (int i = N - 1; i >= 0; i--) if (req_ready[i]) dut_g = i;
    if (r) begin
      checkOutput("ready_in_reset", 64'(req_ready), 64'd0);
      sb.delete();
      m_ptr  = 0;
      m_full = 0;
      foreach (waits[i]) waits[i] = 0;
      return;
    end
    exp_g = -1;
    for (int k = 0; k < N; k++) begin
      if (exp_g < 0 && v[(m_ptr + k) % N]) exp_g = (m_ptr + k) % N;
    end
    can     = !m_full || rr;
    exp_rdy = '0;
    if (can && exp_g >= 0) exp_rdy[exp_g] = 1'b1;
    checkOutput("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (can && exp_g >= 0) begin
      s = {1'b0, op_a[exp_g]} + {1'b0, op_b[exp_g]} + 33'(op_ci[exp_g]);
      sb.push_back('{exp_g, s, cyc});
      issued[exp_g]++;
      for (int i = 0; i < N; i++) begin
        if (!v[i]) waits[i] = 0;
        else if (i != exp_g) waits[i]++;
      end
      checkOutput("fair_wait", 64'(waits[exp_g] <= N - 1), 64'd1);
      waits[exp_g] = 0;
      m_ptr  = (exp_g + 1) % N;
      m_full = 1;
    end else begin
      if (rr) m_full = 0;
      for (int i = 0; i < N; i++) if (!v[i]) waits[i] = 0;
    end
  endtask

  function automatic logic [31:0] randOp();
    case ($urandom_range(0, 4))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h0000_0000;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: any response visible before the posedge must match the queue head.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!rst) begin
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
          checkOutput("rsp_valid", 64'(rsp_valid), 64'd1);
          checkOutput("rsp_id", 64'(rsp_id), 64'(sb[0].id));
          checkOutput("rsp_sum", 64'({rsp_co, rsp_s}), 64'(sb[0].sum));
          if (rsp_valid && rsp_ready) begin
            recv[sb[0].id]++;
            void'(sb.pop_front());
          end
        end else begin
          checkOutput("rsp_idle", 64'(rsp_valid), 64'd0);
        end
      end
    end
  end

  initial begin
    int         g;
    int         fair_seq[6];
    logic [N-1:0] pend;
    fair_seq = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0; op_b[i] = '0; op_ci[i] = 1'b0;
      issued[i] = 0; recv[i] = 0; waits[i] = 0;
    end

    // Reset values
    applyStimulus(1, '0, 0, g);
    applyStimulus(1, '0, 0, g);
    applyStimulus(0, '0, 1, g);
    checkOutput("reset_valid", 64'(rsp_valid), 64'd0);
    checkOutput("reset_s", 64'(rsp_s), 64'd0);
    checkOutput("reset_co", 64'(rsp_co), 64'd0);
    checkOutput("reset_id", 64'(rsp_id), 64'd0);

    // Single request 1+2
    op_a[0] = 32'h0000_0001; op_b[0] = 32'h0000_0002; op_ci[0] = 1'b0;
    applyStimulus(0, 4'b0001, 1, g);
    checkOutput("t1_grant", 64'(g), 64'd0);
    applyStimulus(0, '0, 1, g);
    checkOutput("t1_valid", 64'(rsp_valid), 64'd1);
    checkOutput("t1_s", 64'(rsp_s), 64'd3);
    checkOutput("t1_co", 64'(rsp_co), 64'd0);
    checkOutput("t1_id", 64'(rsp_id), 64'd0);

    // Carry chains
    op_a[0] = 32'hFFFF_FFFF; op_b[0] = 32'h0; op_ci[0] = 1'b1;
    applyStimulus(0, 4'b0001, 1, g);
    applyStimulus(0, '0, 1, g);
    checkOutput("t2_s", 64'(rsp_s), 64'd0);
    checkOutput("t2_co", 64'(rsp_co), 64'd1);
    op_a[0] = 32'h8000_0000; op_b[0] = 32'h8000_0000; op_ci[0] = 1'b0;
    applyStimulus(0, 4'b0001, 1, g);
    applyStimulus(0, '0, 1, g);
    checkOutput("t3_s", 64'(rsp_s), 64'd0);
    checkOutput("t3_co", 64'(rsp_co), 64'd1);

    // Fairness with all requesters held valid
    applyStimulus(1, '0, 0, g);
    for (int i = 0; i < N; i++) begin
      op_a[i] = $urandom; op_b[i] = $urandom; op_ci[i] = 1'($urandom_range(0, 1));
    end
    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, 4'b1111, 1, g);
      checkOutput("t4_id_order", 64'(g), 64'(fair_seq[k]));
      checkOutput("t4_onehot", 64'($countones(req_ready)), 64'd1);
    end

    // Backpressure then drain-and-accept in one cycle
    applyStimulus(1, '0, 0, g);
    applyStimulus(0, 4'b0001, 1, g);
    checkOutput("t5_first", 64'(g), 64'd0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 4'b0110, 0, g);
      checkOutput("t5_stall_ready", 64'(g), 64'(-1));
      checkOutput("t5_stall_id", 64'(rsp_id), 64'd0);
    end
    applyStimulus(0, 4'b0110, 1, g);
    checkOutput("t5_resume", 64'(g), 64'd1);
    applyStimulus(0, 4'b0100, 1, g);
    checkOutput("t5_next", 64'(g), 64'd2);

    // Reset while full
    applyStimulus(1, '0, 0, g);
    applyStimulus(0, 4'b0100, 0, g);
    checkOutput("t6_grant", 64'(g), 64'd2);
    applyStimulus(1, 4'b0100, 0, g);
    applyStimulus(0, '0, 0, g);
    checkOutput("t6_discard", 64'(rsp_valid), 64'd0);
    applyStimulus(0, 4'b0110, 1, g);
    checkOutput("t6_after", 64'(g), 64'd1);

    // Random traffic; requesters hold operands until granted
    applyStimulus(1, '0, 0, g);
    for (int i = 0; i < N; i++) begin
      issued[i] = 0; recv[i] = 0;
    end
    pend = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]  = 1'b1;
          op_a[i]  = randOp();
          op_b[i]  = randOp();
          op_ci[i] = 1'($urandom_range(0, 1));
        end
      end
      applyStimulus(0, pend, ($urandom_range(0, 3) != 0), g);
      if (g >= 0) pend[g] = 1'b0;
    end
    for (int c = 0; c < 8; c++) applyStimulus(0, '0, 1, g);
    #3;
    checkOutput("sb_empty", 64'(sb.size()), 64'd0);
    for (int i = 0; i < N; i++) checkOutput("recv_count", 64'(recv[i]), 64'(issued[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
